// File: rtl/r2r_wave_gen.sv
// r2r_wave_gen: phase-accumulator waveform sequencer driving an 8-bit R-2R DAC.
// Saw / triangle / square / LFSR noise with glitch-free frequency commits.
module r2r_wave_gen #(
  parameter int PHASE_W = 16,
  parameter int DIV_W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [1:0]   cfg_addr,
  input  logic [7:0]   cfg_data,
  output logic [7:0]   dac_code,
  output logic         sample_tick,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [PHASE_W-1:0] phase, phase_n;
  logic [PHASE_W-1:0] freq, freq_n;
  logic [PHASE_W-1:0] shadow, shadow_n;
  logic               pending, pending_n;
  logic [DIV_W-1:0]   div, div_n;
  logic [DIV_W-1:0]   divcnt, divcnt_n;
  logic [1:0]         mode, mode_n;
  logic               run, run_n;
  logic               oneshot, oneshot_n;
  logic [7:0]         lfsr, lfsr_n;
  logic [7:0]         code, code_n;
  logic               tick_q, tick;

  logic               wr;
  logic               run_eff;
  logic [PHASE_W-1:0] f;
  logic [PHASE_W:0]   sum;
  logic [7:0]         lfsr_step;
  logic [7:0]         wave;
  logic               unused_bits;

  assign cfg_ready   = ena & ~pending;
  assign wr          = cfg_valid & cfg_ready;
  assign dac_code    = code;
  assign sample_tick = tick_q & ena;
  assign done        = (state == DONE);
  assign unused_bits = ^cfg_data[7:4];

  // A ctrl write landing this cycle decides the transition, so run=0 beats a tick.
  assign run_eff = (wr && cfg_addr == 2'd3) ? cfg_data[2] : run;
  assign f       = pending ? shadow : freq;
  assign sum     = {1'b0, phase} + {1'b0, f};
  assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  always_comb begin
    wave = sum[PHASE_W-1 -: 8];
    unique case (mode)
      2'd0: wave = sum[PHASE_W-1 -: 8];
      2'd1: wave = sum[PHASE_W-1] ? ~sum[PHASE_W-2 -: 8]
                                  : sum[PHASE_W-2 -: 8];
      2'd2: wave = sum[PHASE_W-1] ? 8'hFF : 8'h00;
      2'd3: wave = lfsr_step;
      default: wave = 8'h00;
    endcase
  end

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    freq_n    = freq;
    shadow_n  = shadow;
    pending_n = pending;
    div_n     = div;
    divcnt_n  = divcnt;
    mode_n    = mode;
    run_n     = run;
    oneshot_n = oneshot;
    lfsr_n    = lfsr;
    code_n    = code;
    tick      = 1'b0;

    unique case (state)
      IDLE: begin
        if (pending) begin
          freq_n    = shadow;
          pending_n = 1'b0;
        end
        if (run_eff) begin
          state_n  = RUN;
          divcnt_n = '0;
        end
      end
      RUN: begin
        if (!run_eff) begin
          state_n = IDLE;
        end else if (divcnt == div) begin
          tick      = 1'b1;
          divcnt_n  = '0;
          freq_n    = f;
          pending_n = 1'b0;
          lfsr_n    = lfsr_step;
          if (oneshot && sum[PHASE_W]) begin
            state_n = DONE;
            phase_n = '0;
            code_n  = 8'h00;
          end else begin
            phase_n = sum[PHASE_W-1:0];
            code_n  = wave;
          end
        end else begin
          divcnt_n = divcnt + 1'b1;
        end
      end
      DONE: begin
        code_n = 8'h00;
        if (!run_eff) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (wr) begin
      unique case (cfg_addr)
        2'd0: shadow_n[7:0] = cfg_data;
        2'd1: begin
          shadow_n[15:8] = cfg_data;
          pending_n      = 1'b1;
        end
        2'd2: begin
          div_n    = cfg_data[DIV_W-1:0];
          divcnt_n = '0;
        end
        2'd3: begin
          mode_n    = cfg_data[1:0];
          run_n     = cfg_data[2];
          oneshot_n = cfg_data[3];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= '0;
      freq    <= '0;
      shadow  <= '0;
      pending <= 1'b0;
      div     <= '0;
      divcnt  <= '0;
      mode    <= 2'd0;
      run     <= 1'b0;
      oneshot <= 1'b0;
      lfsr    <= 8'h01;
      code    <= 8'h00;
      tick_q  <= 1'b0;
    end else if (ena) begin
      state   <= state_n;
      phase   <= phase_n;
      freq    <= freq_n;
      shadow  <= shadow_n;
      pending <= pending_n;
      div     <= div_n;
      divcnt  <= divcnt_n;
      mode    <= mode_n;
      run     <= run_n;
      oneshot <= oneshot_n;
      lfsr    <= lfsr_n;
      code    <= code_n;
      tick_q  <= tick;
    end
  end

endmodule

// File: tb/tb_r2r_wave_gen.sv
// tb_r2r_wave_gen: directed-vector bench for r2r_wave_gen.
// Inputs change just after rising edges or on falling edges; outputs sampled on falling edges.
module tb_r2r_wave_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_addr = 2'd0;
  logic [7:0] cfg_data = 8'h00;
  logic [7:0] dac_code;
  logic       sample_tick;
  logic       done;

  int vectors = 0;
  int miscompares = 0;

  r2r_wave_gen dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .dac_code(dac_code),
    .sample_tick(sample_tick),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic cfg_wr(input logic [1:0] a, input logic [7:0] d);
    int n;
    n = 0;
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    @(negedge clk);
    while (!cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cfg_wr_ready", {15'd0, cfg_ready}, 16'd1);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_tick && n < 50);
    chk("tick_timeout", {15'd0, sample_tick}, 16'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ena = 1'b1;
    cfg_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [7:0] tri_code(input logic [15:0] ph);
    logic [7:0] s;
    s = ph[14:7];
    return ph[15] ? ~s : s;
  endfunction

  initial begin
    logic [15:0] ph;
    int n;

    // reset
    do_reset();
    @(negedge clk);
    chk("rst_code", {8'd0, dac_code}, 16'h00);
    chk("rst_tick", {15'd0, sample_tick}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_ready", {15'd0, cfg_ready}, 16'd1);
    @(posedge clk);
    #1;

    // sawtooth, div=0, wraps 0xFF -> 0x00
    cfg_wr(2'd0, 8'h00);
    cfg_wr(2'd1, 8'h01);
    cfg_wr(2'd2, 8'h00);
    cfg_wr(2'd3, 8'h04);
    @(negedge clk);
    chk("saw_pre_code", {8'd0, dac_code}, 16'h00);
    chk("saw_pre_tick", {15'd0, sample_tick}, 16'd0);
    for (int i = 1; i <= 257; i++) begin
      @(negedge clk);
      chk("saw_code", {8'd0, dac_code}, i[7:0]);
      chk("saw_tick", {15'd0, sample_tick}, 16'd1);
    end

    // triangle, div=3
    do_reset();
    cfg_wr(2'd0, 8'h00);
    cfg_wr(2'd1, 8'h08);
    cfg_wr(2'd2, 8'h03);
    cfg_wr(2'd3, 8'h05);
    @(negedge clk);
    chk("tri_gap0", {15'd0, sample_tick}, 16'd0);
    ph = 16'h0000;
    for (int k = 1; k <= 20; k++) begin
      repeat (3) begin
        @(negedge clk);
        chk("tri_gap", {15'd0, sample_tick}, 16'd0);
      end
      @(negedge clk);
      ph = ph + 16'h0800;
      chk("tri_tick", {15'd0, sample_tick}, 16'd1);
      chk("tri_code", {8'd0, dac_code}, {8'd0, tri_code(ph)});
      if (k == 1)  chk("tri_first", {8'd0, dac_code}, 16'h10);
      if (k == 15) chk("tri_f0", {8'd0, dac_code}, 16'hF0);
      if (k == 16) chk("tri_peak", {8'd0, dac_code}, 16'hFF);
      if (k == 17) chk("tri_down", {8'd0, dac_code}, 16'hEF);
    end

    // one-shot sawtooth
    do_reset();
    cfg_wr(2'd0, 8'h00);
    cfg_wr(2'd1, 8'h40);
    cfg_wr(2'd2, 8'h00);
    cfg_wr(2'd3, 8'h0C);
    @(negedge clk);
    chk("os_pre", {8'd0, dac_code}, 16'h00);
    @(negedge clk);
    chk("os_c1", {8'd0, dac_code}, 16'h40);
    chk("os_d1", {15'd0, done}, 16'd0);
    @(negedge clk);
    chk("os_c2", {8'd0, dac_code}, 16'h80);
    @(negedge clk);
    chk("os_c3", {8'd0, dac_code}, 16'hC0);
    chk("os_d3", {15'd0, done}, 16'd0);
    @(negedge clk);
    chk("os_wrap_code", {8'd0, dac_code}, 16'h00);
    chk("os_wrap_tick", {15'd0, sample_tick}, 16'd1);
    chk("os_wrap_done", {15'd0, done}, 16'd1);
    repeat (3) begin
      @(negedge clk);
      chk("os_hold_tick", {15'd0, sample_tick}, 16'd0);
      chk("os_hold_done", {15'd0, done}, 16'd1);
      chk("os_hold_code", {8'd0, dac_code}, 16'h00);
    end
    @(posedge clk);
    #1;
    cfg_wr(2'd3, 8'h00);
    @(negedge clk);
    chk("os_idle_done", {15'd0, done}, 16'd0);
    chk("os_idle_code", {8'd0, dac_code}, 16'h00);

    // glitch-free frequency update, div=7
    do_reset();
    cfg_wr(2'd0, 8'h00);
    cfg_wr(2'd1, 8'h01);
    cfg_wr(2'd2, 8'h07);
    cfg_wr(2'd3, 8'h04);
    wait_tick();
    chk("gl_c1", {8'd0, dac_code}, 16'h01);
    wait_tick();
    chk("gl_c2", {8'd0, dac_code}, 16'h02);
    cfg_valid = 1'b1;
    cfg_addr  = 2'd1;
    cfg_data  = 8'h02;
    @(posedge clk);
    #1 cfg_data = 8'h03;
    n = 0;
    do begin
      @(negedge clk);
      if (!sample_tick) begin
        chk("gl_ready_low", {15'd0, cfg_ready}, 16'd0);
        n++;
      end
    end while (!sample_tick && n < 20);
    chk("gl_wait_cycles", n[15:0], 16'd7);
    chk("gl_commit_code", {8'd0, dac_code}, 16'h04);
    chk("gl_ready_back", {15'd0, cfg_ready}, 16'd1);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    @(negedge clk);
    chk("gl_held_accepted", {15'd0, cfg_ready}, 16'd0);
    wait_tick();
    chk("gl_step3", {8'd0, dac_code}, 16'h07);
    wait_tick();
    chk("gl_step3b", {8'd0, dac_code}, 16'h0A);

    // noise, freeze, reset mid-run
    do_reset();
    cfg_wr(2'd2, 8'h00);
    cfg_wr(2'd3, 8'h07);
    @(negedge clk);
    chk("nz_pre", {8'd0, dac_code}, 16'h00);
    @(negedge clk);
    chk("nz_c1", {8'd0, dac_code}, 16'h02);
    @(negedge clk);
    chk("nz_c2", {8'd0, dac_code}, 16'h04);
    @(negedge clk);
    chk("nz_c3", {8'd0, dac_code}, 16'h08);
    @(negedge clk);
    chk("nz_c4", {8'd0, dac_code}, 16'h11);
    ena = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("frz_code", {8'd0, dac_code}, 16'h11);
      chk("frz_tick", {15'd0, sample_tick}, 16'd0);
      chk("frz_ready", {15'd0, cfg_ready}, 16'd0);
    end
    ena = 1'b1;
    @(negedge clk);
    chk("nz_resume_code", {8'd0, dac_code}, 16'h23);
    chk("nz_resume_tick", {15'd0, sample_tick}, 16'd1);
    rst = 1'b1;
    ena = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ena = 1'b1;
    @(negedge clk);
    chk("mrst_code", {8'd0, dac_code}, 16'h00);
    chk("mrst_tick", {15'd0, sample_tick}, 16'd0);
    chk("mrst_ready", {15'd0, cfg_ready}, 16'd1);
    @(negedge clk);
    chk("mrst_idle", {8'd0, dac_code}, 16'h00);
    @(posedge clk);
    #1;
    cfg_wr(2'd3, 8'h07);
    @(negedge clk);
    @(negedge clk);
    chk("mrst_lfsr", {8'd0, dac_code}, 16'h02);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/r2r_wave_gen.md
# r2r_wave_gen

Digital waveform sequencer that produces the 8-bit code driving the on-chip R-2R DAC (DAC inputs d0..d7 = dac_code[0..7]). A byte-wide register port configures a phase accumulator, a sample-rate divider and a waveform mode: sawtooth, triangle, square or LFSR noise. New codes are emitted at a programmable rate, with glitch-free frequency updates and an optional one-shot mode.

## Interface
- PHASE_W, 16, phase accumulator width; the frequency word is also PHASE_W bits, loaded as two bytes, so PHASE_W is fixed at 16.
- DIV_W, 8, sample-rate divider width.

- clk  in  1  system clock; the block uses a single clock.
- rst  in  1  reset, synchronous and active-high.
- ena  in  1  design enable; when 0, all state holds and cfg_ready=0.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted when cfg_valid&cfg_ready at a rising edge; cfg_ready = ena & ~pending (combinational).
- cfg_addr  in  2  0=freq[7:0], 1=freq[15:8], 2=div, 3=ctrl {—,—,—,—,oneshot,run,mode[1:0]}.
- cfg_data  in  8  write data.
- dac_code  out  8  registered DAC code.
- sample_tick  out  1  registered 1-cycle pulse, high in the cycle after each dac_code update.
- done  out  1  high while in state DONE.

## Operation
- Reset values: dac_code=0x00, sample_tick=0, done=0, phase=0, freq=0, freq_shadow=0, pending=0, div=0, mode=0, run=0, oneshot=0, divcnt=0, lfsr=0x01, state=IDLE.
- Writes to addr 0 go to freq_shadow[7:0]. Writes to addr 1 go to freq_shadow[15:8] and set pending. Writes to addr 2 set div immediately and clear divcnt. Writes to addr 3 set mode, run and oneshot.
- States:
  - IDLE: no ticks, dac_code holds. run=1 → RUN; divcnt←0.
  - RUN: divcnt increments each cycle. When divcnt==div, a tick occurs and divcnt←0. run=0 → IDLE; dac_code holds.
  - DONE: dac_code←0x00, no ticks, done=1. run=0 → IDLE.
- On a tick: f = pending ? freq_shadow : freq. Then freq←f, pending←0, and {carry, phase} ← phase + f. lfsr shifts left with lsb ← b7^b5^b4^b3. dac_code ← code(new phase, new lfsr).
- code by mode:
  - 0 saw: phase[15:8].
  - 1 triangle: phase[15] ? ~phase[14:7] : phase[14:7].
  - 2 square: phase[15] ? 0xFF : 0x00.
  - 3 noise: lfsr.
- In IDLE, pending commits (freq←freq_shadow, pending←0) on the next enabled edge.
- Oneshot: a tick with carry=1 and oneshot=1 → DONE. phase←0 and dac_code←0x00 on that edge; sample_tick still pulses.
- Mode change takes effect at the next tick; there is no immediate recompute.
- ena=0 freezes every register, including divcnt. sample_tick is forced 0 in that case.

## Timing
- Divider period = div+1 cycles. div=0 gives a tick every cycle.
- Write ctrl run=1 at edge E → state=RUN after E. The first tick edge is E+div+1, and dac_code changes on that edge. sample_tick is high during the cycle after that edge.
- Frequency change: the addr-1 write at edge W sets pending. cfg_ready is low from W until the commit edge, and high again in the cycle after the commit. The new frequency is used for the step of the commit tick itself.
- Simultaneous ctrl run=0 write and tick: the tick is suppressed and the state goes to IDLE; the run=0 write wins.
- Synchronous rst asserted mid-operation: all registers return to reset values on that edge, regardless of ena.

## Test plan
- Reset: assert rst 2 cycles, ena=1 → dac_code=0x00, sample_tick=0, done=0, cfg_ready=1.
- Saw: freq=0x0100, div=0, ctrl=0x04 (run, mode 0) → dac_code = 0x01, 0x02, … one per cycle. 0xFF is followed by 0x00, with sample_tick high every cycle.
- Triangle: freq=0x0800, div=3, ctrl=0x05 → ticks every 4 cycles, codes 0x10, 0x20, …, 0xF0, 0xFF, 0xEF, …, with sample_tick every 4th cycle.
- One-shot saw: freq=0x4000, div=0, ctrl=0x0C → codes 0x40, 0x80, 0xC0, then 0x00 with done=1. There are no further ticks. Writing ctrl=0x00 then returns the block to IDLE with done=0.
- Glitch-free update: running saw at freq=0x0100 with div=7, write freq hi=0x02 → cfg_ready=0 until the next tick, at which the step becomes 0x0200. A cfg_valid held during that window is accepted only once cfg_ready returns to 1.
- Noise and freeze: ctrl=0x07, div=0 → codes 0x02, 0x04, 0x08, 0x11. Dropping ena for 5 cycles holds the code, and sample_tick stays 0. Asserting rst mid-run → dac_code=0x00 and lfsr=0x01.
